// File: rtl/promedio_uart_tx.sv
// UART transmitter for the averager result: start bit, N data bits LSB first and a stop bit.
// Defining PROMEDIO_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module promedio_uart_tx #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         data_valid,
  input  logic [N-1:0] data_in,
  output logic         tx,
  output logic         busy,
  output logic         overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PROMEDIO_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [N-1:0]    shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
`ifdef PROMEDIO_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif
  logic            baud_done;
  logic            accept;

  assign baud_done = (cnt_q == BAUD_LAST);
  // A strobe is taken when idle, or in the last stop cycle so frames run back to back.
  assign accept    = en && data_valid &&
                     ((state_q == IDLE) || ((state_q == STOP) && baud_done));

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    overrun_d = overrun_q;
`ifdef PROMEDIO_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      bit_d     = '0;
      overrun_d = 1'b0;
    end else begin
      if (state_q != IDLE) cnt_d = baud_done ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        START: if (baud_done) state_d = DATA;
        DATA: begin
          if (baud_done) begin
            shift_d = shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
`ifdef PROMEDIO_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
`ifdef PROMEDIO_TX_PARITY_EN
        PARITY: if (baud_done) state_d = STOP;
`endif
        STOP: if (baud_done) state_d = IDLE;
        default: ;
      endcase
      if (data_valid && !accept) overrun_d = 1'b1;
      if (accept) begin
        state_d = START;
        cnt_d   = '0;
        bit_d   = '0;
        shift_d = data_in;
`ifdef PROMEDIO_TX_PARITY_EN
        parity_d = ^data_in;
`endif
      end
    end
  end

  // Outputs are decoded from the next state so the registered pins change on the same edge.
  always_comb begin
    busy_d = (state_d != IDLE);
    tx_d   = 1'b1;
    unique case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef PROMEDIO_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PROMEDIO_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef PROMEDIO_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_promedio_uart_tx.sv
// Self-checking bench for promedio_uart_tx (N=8, CLKS_PER_BIT=4) against a frame-position model.
// Honours PROMEDIO_TX_PARITY_EN the same way as the design.
module tb_promedio_uart_tx;

  localparam int N = 8;
  localparam int C = 4;
`ifdef PROMEDIO_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LEN = NBITS * C;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         data_valid;
  logic [N-1:0] data_in;
  logic         tx;
  logic         busy;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  promedio_uart_tx #(.N(N), .CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .data_valid (data_valid),
    .data_in    (data_in),
    .tx         (tx),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference: a frame is a bit vector (transmit order = index); position counts cycles since capture.
  logic        m_active;
  int          m_pos;
  logic [10:0] m_frame;
  logic        m_over;

  task automatic model_reset();
    m_active = 1'b0;
    m_pos    = 0;
    m_frame  = '0;
    m_over   = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic v, input logic [N-1:0] d);
    logic was_active, last_cycle;
    if (!e) begin
      m_active = 1'b0;
      m_over   = 1'b0;
    end else begin
      was_active = m_active;
      last_cycle = m_active && (m_pos == LEN - 1);
      if (m_active) begin
        m_pos++;
        if (m_pos == LEN) m_active = 1'b0;
      end
      if (v) begin
        if (!was_active || last_cycle) begin
`ifdef PROMEDIO_TX_PARITY_EN
          m_frame = {1'b1, ^d, d, 1'b0};
`else
          m_frame = {2'b01, d, 1'b0};
`endif
          m_active = 1'b1;
          m_pos    = 0;
        end else begin
          m_over = 1'b1;
        end
      end
    end
  endtask

  function automatic logic exp_tx();
    return m_active ? m_frame[m_pos / C] : 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic cycle(input logic e, input logic v, input logic [N-1:0] d);
    en = e;
    data_valid = v;
    data_in = d;
    @(posedge clk);
    model_step(e, v, d);
    @(negedge clk);
    check("tx", tx, exp_tx());
    check("busy", busy, m_active);
    check("overrun", overrun, m_over);
  endtask

  task automatic run_frame(input logic [N-1:0] d, output int busy_cnt);
    cycle(1'b1, 1'b1, d);
    busy_cnt = 0;
    repeat (LEN) begin
      if (busy) busy_cnt++;
      cycle(1'b1, 1'b0, '0);
    end
  endtask

  typedef struct {
    logic [N-1:0] data;
    logic [10:0]  seq;   // transmitted bit i at index i
  } vec_t;

  vec_t vecs[8];

  initial begin
    int bcnt;
    logic e, v;

`ifdef PROMEDIO_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{8'h3C, 11'b1_0_00111100_0};
    vecs[2] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[3] = '{8'h00, 11'b1_0_00000000_0};
    vecs[4] = '{8'h81, 11'b1_0_10000001_0};
    vecs[5] = '{8'h55, 11'b1_0_01010101_0};
    vecs[6] = '{8'h07, 11'b1_1_00000111_0};
    vecs[7] = '{8'h03, 11'b1_0_00000011_0};
`else
    vecs[0] = '{8'hA5, 11'b0_1_10100101_0};
    vecs[1] = '{8'h3C, 11'b0_1_00111100_0};
    vecs[2] = '{8'hFF, 11'b0_1_11111111_0};
    vecs[3] = '{8'h00, 11'b0_1_00000000_0};
    vecs[4] = '{8'h81, 11'b0_1_10000001_0};
    vecs[5] = '{8'h55, 11'b0_1_01010101_0};
    vecs[6] = '{8'h07, 11'b0_1_00000111_0};
    vecs[7] = '{8'h03, 11'b0_1_00000011_0};
`endif

    reset = 1'b1;
    en = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    model_reset();
    @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 1'b0, '0);

    // Table: every bit period and the exact busy length of a lone frame.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, vecs[i].data);
      bcnt = 0;
      for (int p = 0; p < LEN; p++) begin
        check($sformatf("vec%0d_bit%0d", i, p / C), tx, vecs[i].seq[p / C]);
        if (busy) bcnt++;
        cycle(1'b1, 1'b0, '0);
      end
      check($sformatf("vec%0d_busy_len", i), bcnt, LEN);
      check($sformatf("vec%0d_overrun", i), overrun, 1'b0);
      cycle(1'b1, 1'b0, '0);
    end

    // Back-to-back: second strobe in the last stop cycle.
    cycle(1'b1, 1'b1, 8'hA5);
    bcnt = 0;
    for (int p = 0; p < 2 * LEN; p++) begin
      if (busy) bcnt++;
      cycle(1'b1, (p == LEN - 1), 8'h3C);
    end
    check("b2b_busy_len", bcnt, 2 * LEN);
    check("b2b_overrun", overrun, 1'b0);
    check("b2b_idle_after", busy, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, '0);

    // Overrun: strobe mid-frame is dropped, flag sticks until en drops.
    cycle(1'b1, 1'b1, 8'hFF);
    for (int p = 0; p < LEN; p++) cycle(1'b1, (p == 9), 8'h00);
    check("ovr_set", overrun, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, '0);
    check("ovr_sticky", overrun, 1'b1);
    cycle(1'b0, 1'b0, '0);
    check("ovr_clear", overrun, 1'b0);

    // Enable drop mid-frame, then a clean 0x81 frame.
    cycle(1'b1, 1'b1, 8'h00);
    repeat (14) cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h99);
    check("endrop_tx", tx, 1'b1);
    check("endrop_busy", busy, 1'b0);
    cycle(1'b1, 1'b0, '0);
    run_frame(8'h81, bcnt);
    check("endrop_recover_len", bcnt, LEN);

    // Asynchronous reset in the middle of the data bits.
    cycle(1'b1, 1'b1, 8'hA5);
    repeat (9) cycle(1'b1, 1'b0, '0);
    #2 reset = 1'b1;
    #1;
    check("async_tx", tx, 1'b1);
    check("async_busy", busy, 1'b0);
    model_reset();
    en = 1'b1;
    data_valid = 1'b1;
    data_in = 8'h12;
    @(posedge clk);
    @(negedge clk);
    check("reset_hold_busy", busy, 1'b0);
    reset = 1'b0;
    cycle(1'b1, 1'b0, '0);
    run_frame(8'h55, bcnt);
    check("async_recover_len", bcnt, LEN);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      e = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 24) == 0);
      if (m_active && (m_pos == LEN - 1) && ($urandom_range(0, 1) == 1)) v = 1'b1;
      cycle(e, v, N'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/promedio_uart_tx.md
Name: promedio_uart_tx

Overview:
Reader/transmitter for the temperature-sensor averaging result. Captures the N-bit accumulated value when the averager pulses its ready strobe, then serialises it off-chip as an asynchronous UART frame on a single output pin. Sits between the averaging accumulator and the chip output pins; the one-cycle ready pulse is its only handshake.

Parameters:
N, 8, data width in bits; also the number of data bits per frame.
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
en  input  1  block enable; low aborts any frame and holds idle
data_valid  input  1  single-cycle strobe from the averager's sum_redy
data_in  input  N  averaged value; sampled only when data_valid=1
tx  output  1  UART serial line, idle high
busy  output  1  high while a frame is in progress
overrun  output  1  sticky: a data_valid arrived and was dropped

Behaviour:
- Clocking: one clock, clk. reset is asynchronous and active-high.
- Reset values: tx=1, busy=0, overrun=0, state=IDLE, all counters 0, shift register 0.
- All outputs registered; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, (PARITY if enabled), STOP.
- IDLE: tx=1, busy=0. If en=1 and data_valid=1, load data_in into the shift register; next state START.
- Latency: data_valid sampled on edge k -> tx=0 and busy=1 from edge k onward.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: N bits, LSB first, each held CLKS_PER_BIT cycles; bit index counts 0..N-1, then -> PARITY/STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles -> IDLE, busy=0.
- Frame length: (N+2)*CLKS_PER_BIT cycles, or (N+3)*CLKS_PER_BIT with parity.
- Baud counter: counts 0..CLKS_PER_BIT-1; state or bit advances when it reaches CLKS_PER_BIT-1. Width is clog2(CLKS_PER_BIT), minimum 1.
- Back-to-back: data_valid=1 in the final cycle of STOP -> capture, go directly to START (tx=0 next cycle), busy stays 1, overrun not set.
- data_valid=1 in any other cycle while busy=1 -> data dropped, in-flight frame unaffected, overrun<=1.
- overrun is sticky; cleared only by reset or en=0.
- en=0 at any time: next edge forces IDLE, tx=1, busy=0, overrun=0, counters 0. The partial frame is abandoned with no stop-bit completion.
- en=0 and data_valid=1 in the same cycle: data ignored.
- Asynchronous reset mid-frame: tx returns to 1 immediately; no capture on the reset-release edge unless data_valid=1 with reset already low.

Optional Feature:
PROMEDIO_TX_PARITY_EN: when defined, a PARITY state follows DATA. It transmits even parity, the XOR of the N captured bits, for CLKS_PER_BIT cycles before STOP. When undefined, no PARITY state or parity logic exists, and DATA goes directly to STOP.

Test Plan:
- N=8, CLKS_PER_BIT=4, data_in=0xA5 pulsed 1 cycle -> tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; busy high exactly 40 cycles; overrun=0.
- Same config, 0xA5 then 0x3C pulsed in the final STOP cycle -> two contiguous frames, no idle gap, busy continuously high 80 cycles, overrun=0.
- Pulse 0xFF, then a second pulse 0x00 at cycle 10 of the frame -> 0xFF frame transmitted intact, 0x00 never sent, overrun=1 until en dropped, then 0.
- Start a 0x00 frame, drop en at cycle 15 -> next edge tx=1, busy=0; next pulse of 0x81 with en=1 sends a clean full frame.
- Assert reset asynchronously mid-DATA (between edges) -> tx=1, busy=0 immediately, without waiting for a clock edge; recovery frame of 0x55 correct.
- With PROMEDIO_TX_PARITY_EN, data 0x07 -> parity bit 1, frame 44 cycles; data 0x03 -> parity bit 0.
